// File: rtl/bf_fetch_decode.sv
// Brainfuck fetch/decode front end: walks a synchronous program ROM, offers
// arithmetic/IO commands to an execute stage over a valid/ready handshake and
// resolves '[' / ']' itself by scanning the ROM for the matching bracket.
module bf_fetch_decode #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addrOut,
    input  logic [7:0]        dataIn,
    input  logic              cellZero,
    output logic              cmdValid,
    input  logic              cmdReady,
    output logic [2:0]        cmdOp,
    output logic              halted,
    output logic              error
);
    typedef enum logic [2:0] {
        FETCH, DECODE, ISSUE, SCAN_WAIT, SCAN_CHECK, HALT
    } state_t;

    localparam logic [ADDR_W-1:0]  PC_MAX    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]  PC_ONE    = ADDR_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               fwd_q, fwd_d;
    logic [2:0]         op_q, op_d;
    logic               err_q, err_d;

    logic       is_cmd;
    logic [2:0] dec_op;
    logic       is_open, is_close, scan_inc, scan_dec;
    logic       pc_top, pc_bot;

    assign is_open  = (dataIn == 8'h5B);
    assign is_close = (dataIn == 8'h5D);
    // Forward scans nest on '[' and unwind on ']'; backward scans the reverse.
    assign scan_inc = fwd_q ? is_open  : is_close;
    assign scan_dec = fwd_q ? is_close : is_open;
    assign pc_top   = (pc_q == PC_MAX);
    assign pc_bot   = (pc_q == '0);

    // Map the six executable characters onto command codes
    always_comb begin
        is_cmd = 1'b1;
        dec_op = 3'd0;
        case (dataIn)
            8'h2B:   dec_op = 3'd0;
            8'h2D:   dec_op = 3'd1;
            8'h3E:   dec_op = 3'd2;
            8'h3C:   dec_op = 3'd3;
            8'h2E:   dec_op = 3'd4;
            8'h2C:   dec_op = 3'd5;
            default: is_cmd = 1'b0;
        endcase
    end

    // Next-state logic: sequencing, bracket scans and halt conditions
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        fwd_d   = fwd_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                if (is_cmd) begin
                    op_d    = dec_op;
                    state_d = ISSUE;
                end else if (dataIn == 8'h00) begin
                    state_d = HALT;
                end else if (is_open && cellZero) begin
                    depth_d = DEPTH_ONE;
                    fwd_d   = 1'b1;
                    if (pc_top) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = SCAN_WAIT;
                    end
                end else if (is_close && !cellZero) begin
                    depth_d = DEPTH_ONE;
                    fwd_d   = 1'b0;
                    if (pc_bot) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = pc_q - PC_ONE;
                        state_d = SCAN_WAIT;
                    end
                end else if (pc_top) begin
                    // Fall-through bracket or comment byte at the last address
                    state_d = HALT;
                end else begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                if (cmdReady) begin
                    if (pc_top) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = FETCH;
                    end
                end
            end
            SCAN_WAIT: state_d = SCAN_CHECK;
            SCAN_CHECK: begin
                if (dataIn == 8'h00 || (scan_inc && depth_q == DEPTH_MAX)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else if (scan_dec && depth_q == DEPTH_ONE) begin
                    // Matching bracket found: resume just past it
                    depth_d = '0;
                    if (pc_top) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = FETCH;
                    end
                end else begin
                    if (scan_inc)      depth_d = depth_q + DEPTH_ONE;
                    else if (scan_dec) depth_d = depth_q - DEPTH_ONE;
                    if (fwd_q ? pc_top : pc_bot) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = fwd_q ? (pc_q + PC_ONE) : (pc_q - PC_ONE);
                        state_d = SCAN_WAIT;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            depth_q <= '0;
            fwd_q   <= 1'b1;
            op_q    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fwd_q   <= fwd_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign addrOut  = pc_q;
    assign cmdValid = (state_q == ISSUE);
    assign cmdOp    = op_q;
    assign halted   = (state_q == HALT);
    assign error    = err_q;
endmodule

// File: tb/tb_bf_fetch_decode.sv
// Bench for bf_fetch_decode: synchronous ROM, a tape-keeping execute stage,
// and a straightforward Brainfuck interpreter as the reference.
module tb_bf_fetch_decode;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] addrOut;
    logic [7:0] dataIn = 8'h00;
    logic       cellZero;
    logic       cmdValid;
    logic       cmdReady = 1'b1;
    logic [2:0] cmdOp;
    logic       halted, error;

    int checks = 0;
    int failures = 0;

    logic [7:0] rom       [16];
    logic [7:0] tape_init [16];
    logic [7:0] tape      [16];
    logic [3:0] ptr;
    bit         force_cz = 1'b0;
    int         cyc;
    int         acc_op[$];
    int         acc_cyc[$];
    int         base;

    int exp_ops[$];
    bit exp_done;
    bit exp_err;
    int exp_pc;

    bf_fetch_decode #(.ADDR_W(4), .DEPTH_W(4)) dut (
        .clk(clk), .reset(reset), .addrOut(addrOut), .dataIn(dataIn),
        .cellZero(cellZero), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM
    always @(posedge clk) dataIn <= rom[addrOut];

    assign cellZero = force_cz || (tape[ptr] == 8'h00);

    // Execute stage: records accepted commands and updates the tape
    always @(posedge clk) begin
        if (reset) begin
            tape <= tape_init;
            ptr  <= 4'd0;
            cyc  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (cmdValid && cmdReady) begin
                acc_op.push_back(int'(cmdOp));
                acc_cyc.push_back(cyc + 1);
                case (cmdOp)
                    3'd0:    tape[ptr] <= tape[ptr] + 8'd1;
                    3'd1:    tape[ptr] <= tape[ptr] - 8'd1;
                    3'd2:    ptr <= ptr + 4'd1;
                    3'd3:    ptr <= ptr - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 16; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    // Reference interpreter: runs up to 'limit' instructions (a whole bracket
    // search counts as one) and records the commands it would execute.
    task automatic model(input int limit);
        logic [7:0] t [16];
        logic [3:0] p;
        logic [7:0] b;
        int  pc, q, npc, depth;
        bit  cz;
        exp_ops.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_pc   = 0;
        t  = tape_init;
        p  = 4'd0;
        pc = 0;
        for (int s = 0; s < limit && !exp_done; s++) begin
            b   = rom[pc];
            cz  = force_cz || (t[p] == 8'h00);
            npc = pc + 1;
            q   = pc;
            case (b)
                8'h2B: begin exp_ops.push_back(0); t[p] = t[p] + 8'd1; end
                8'h2D: begin exp_ops.push_back(1); t[p] = t[p] - 8'd1; end
                8'h3E: begin exp_ops.push_back(2); p = p + 4'd1; end
                8'h3C: begin exp_ops.push_back(3); p = p - 4'd1; end
                8'h2E: exp_ops.push_back(4);
                8'h2C: exp_ops.push_back(5);
                8'h00: exp_done = 1'b1;
                8'h5B: if (cz) begin
                    depth = 1;
                    while (depth > 0 && !exp_done) begin
                        q++;
                        if (q > 15) begin exp_done = 1'b1; exp_err = 1'b1; q = 15; end
                        else if (rom[q] == 8'h00) begin exp_done = 1'b1; exp_err = 1'b1; end
                        else if (rom[q] == 8'h5B) begin
                            if (depth == 15) begin exp_done = 1'b1; exp_err = 1'b1; end
                            else depth++;
                        end else if (rom[q] == 8'h5D) depth--;
                    end
                    npc = q + 1;
                end
                8'h5D: if (!cz) begin
                    depth = 1;
                    while (depth > 0 && !exp_done) begin
                        q--;
                        if (q < 0) begin exp_done = 1'b1; exp_err = 1'b1; q = 0; end
                        else if (rom[q] == 8'h00) begin exp_done = 1'b1; exp_err = 1'b1; end
                        else if (rom[q] == 8'h5D) begin
                            if (depth == 15) begin exp_done = 1'b1; exp_err = 1'b1; end
                            else depth++;
                        end else if (rom[q] == 8'h5B) depth--;
                    end
                    npc = q + 1;
                end
                default: ;
            endcase
            if (exp_done) exp_pc = q;
            else if (npc > 15) begin exp_done = 1'b1; exp_pc = 15; end
            else pc = npc;
        end
    endtask

    task automatic start(input bit rdy);
        @(negedge clk);
        reset    = 1'b1;
        cmdReady = rdy;
        @(negedge clk);
        @(negedge clk);
        base  = acc_op.size();
        reset = 1'b0;
    endtask

    task automatic run(input int budget, input bit rnd);
        for (int i = 0; i < budget && !halted; i++) begin
            @(negedge clk);
            cmdReady = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    // Compare accepted commands against the model; 'full' means the model
    // halted, so the DUT must have halted in the same way.
    task automatic compare(input string tag, input bit full);
        int n = acc_op.size() - base;
        if (full) begin
            chk({tag, "/count"}, n, exp_ops.size());
            chk({tag, "/halted"}, halted, 1'b1);
            chk({tag, "/error"}, error, exp_err);
            chk({tag, "/addr"}, addrOut, exp_pc);
        end else begin
            chk({tag, "/running"}, halted, 1'b0);
            chk({tag, "/prefix"}, n <= exp_ops.size(), 1'b1);
        end
        for (int i = 0; i < n && i < exp_ops.size(); i++)
            chk($sformatf("%s/op%0d", tag, i), acc_op[base + i], exp_ops[i]);
    endtask

    initial begin
        string alpha;
        int    len;
        for (int i = 0; i < 16; i++) begin
            rom[i]       = 8'h00;
            tape_init[i] = 8'h00;
        end

        // Asynchronous reset takes effect before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst/addr", addrOut, 0);
        chk("rst/valid", cmdValid, 0);
        chk("rst/op", cmdOp, 0);
        chk("rst/halted", halted, 0);
        chk("rst/error", error, 0);

        // Looping program with natural cell values
        load("+[.+]>-[.-]");
        start(1'b1);
        run(60, 1'b0);
        model(400);
        chk("loop/first_cyc", (acc_op.size() > base) ? acc_cyc[base] : -1, 3);
        compare("loop", 1'b0);

        // Same program, cell forced zero: both loops skipped by forward scans
        force_cz = 1'b1;
        start(1'b1);
        run(300, 1'b0);
        model(400);
        compare("skip", 1'b1);
        force_cz = 1'b0;

        // Back-pressure: command held stable while ready is low
        load("+");
        start(1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall/valid%0d", i), cmdValid, 1'b1);
            chk($sformatf("stall/op%0d", i), cmdOp, 0);
            chk($sformatf("stall/addr%0d", i), addrOut, 0);
            @(negedge clk);
        end
        run(20, 1'b0);
        model(400);
        compare("stall", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt/addr_frozen", addrOut, 1);
            chk("halt/valid", cmdValid, 1'b0);
        end

        // Unmatched bracket found by a forward scan
        load("[[+]");
        start(1'b1);
        run(200, 1'b0);
        model(400);
        compare("unmatched", 1'b1);

        // Reset in the middle of a backward scan
        load("+[.+]>-[.-]");
        start(1'b1);
        for (int i = 0; i < 60 && (acc_op.size() - base) < 3; i++) @(negedge clk);
        chk("mid/reached", (acc_op.size() - base) >= 3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("mid/scan_addr", addrOut, 3);
        chk("mid/scan_valid", cmdValid, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mid/rst_addr", addrOut, 0);
        chk("mid/rst_valid", cmdValid, 0);
        chk("mid/rst_op", cmdOp, 0);
        chk("mid/rst_halted", halted, 0);
        chk("mid/rst_error", error, 0);
        @(negedge clk);
        @(negedge clk);
        base  = acc_op.size();
        reset = 1'b0;
        chk("mid/restart_addr", addrOut, 0);
        run(30, 1'b0);
        model(400);
        chk("mid/first_cyc", (acc_op.size() > base) ? acc_cyc[base] : -1, 3);
        compare("mid", 1'b0);

        // Random programs, random tape and random back-pressure
        alpha = "+-><.,[[]]x";
        for (int k = 0; k < 20; k++) begin
            len = ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                rom[i]       = (i < len) ? alpha[$urandom_range(0, alpha.len() - 1)] : 8'h00;
                tape_init[i] = 8'($urandom_range(0, 2));
            end
            model(400);
            start(1'b1);
            if (exp_done) run(6000, 1'b1);
            else          run(300, 1'b1);
            compare($sformatf("rnd%0d", k), exp_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
